sipo_frame_rx: RTL and testbench

- Serial-in/parallel-out frame receiver sitting directly downstream of the 4-stage serial shift register; consumes its Q output one bit per clock.
- Detects a start bit, deserialises WIDTH data bits LSB-first, checks the stop bit, and presents the word on a single-entry output buffer with valid/ready handshake.
- Reports framing and overrun errors.

---
 rtl/sipo_frame_rx.sv | 142 ++++++++++++++
 tb/tb_sipo_frame_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial-in/parallel-out frame receiver.
//
// Consumes one bit of D per clock. A frame is a start bit (1), WIDTH data
// bits LSB-first, an optional even-parity bit, and a stop bit (0). Good words
// land in a single-entry output buffer with a valid/ready handshake.
// Bad frames pulse frame_err. Good frames that arrive while the buffer is
// full raise the sticky overrun flag.
//
// Optional feature macro: SIPO_PARITY_CHK_EN
//   defined   -> a PARITY state follows the data bits; even parity is checked
//   undefined -> no parity bit; frame is WIDTH+2 cycles long
//
// state  | meaning
// IDLE   | waiting for a start bit (D=1)
// SHIFT  | capturing data bits LSB-first, one per cycle
// PARITY | capturing the even-parity bit (parity build only)
// STOP   | checking the stop bit and committing the word to the buffer
module sipo_frame_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             D,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SIPO_PARITY_CHK_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd3
  } state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             consume;
  logic             frame_ok;
`ifdef SIPO_PARITY_CHK_EN
  logic             par_bit;
`endif

  assign consume = data_valid & data_ready;

  // Frame quality as seen in the STOP cycle: stop bit low, and parity even if checked
  always_comb begin
    frame_ok = ~D;
`ifdef SIPO_PARITY_CHK_EN
    frame_ok = frame_ok & ~(^shreg ^ par_bit);
`endif
  end

  // Receive FSM, output buffer and error flags, all registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
`ifdef SIPO_PARITY_CHK_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;

      // A handshake empties the buffer and clears a pending overrun; a commit
      // below in the same cycle overrides the data_valid drop.
      if (consume) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (D) begin
            state <= SHIFT;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        SHIFT: begin
          shreg[cnt] <= D;
          cnt        <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
`ifdef SIPO_PARITY_CHK_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end

`ifdef SIPO_PARITY_CHK_EN
        PARITY: begin
          par_bit <= D;
          state   <= STOP;
        end
`endif

        STOP: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!frame_ok) begin
            frame_err <= 1'b1;
          end else if (!data_valid || consume) begin
            data_out   <= shreg;
            data_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx (WIDTH=8).
// Expected words are queued when a good frame is driven and popped when the
// DUT presents them. Build with +define+SIPO_PARITY_CHK_EN to cover parity.
module tb_sipo_frame_rx;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             D;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             frame_err;
  logic             overrun;
  logic             busy;

  int n_pass;
  int n_total;
  logic [WIDTH-1:0] sb_q[$];

  sipo_frame_rx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .D          (D),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // Present one bit for one clock; outputs are then sampled 1 time unit later.
  task automatic drive_bit(input logic d);
    D = d;
    @(posedge clk);
    #1;
  endtask

  // Start bit, data LSB-first and (parity build) the correct parity bit; no stop bit.
  task automatic send_body(input logic [WIDTH-1:0] w);
    drive_bit(1'b1);
    for (int i = 0; i < WIDTH; i++) drive_bit(w[i]);
`ifdef SIPO_PARITY_CHK_EN
    drive_bit(^w);
`endif
  endtask

  task automatic test_reset();
    logic seen;
    rst = 1'b1; data_ready = 1'b0;
    drive_bit(1'b0); drive_bit(1'b1);
    rst = 1'b0;
    n_total++; if (data_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", data_valid); else n_pass++;
    n_total++; if (data_out !== '0) $display("FAIL reset_data got=%h exp=00", data_out); else n_pass++;
    n_total++; if ({frame_err, overrun, busy} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {frame_err, overrun, busy}); else n_pass++;

    // frame aborted by a 2-cycle reset while D toggles
    drive_bit(1'b1);
    n_total++; if (busy !== 1'b1) $display("FAIL reset_busy_start got=%b exp=1", busy); else n_pass++;
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    rst = 1'b1;
    drive_bit(1'b0); drive_bit(1'b1);
    rst = 1'b0;
    n_total++; if ({data_valid, frame_err, overrun, busy} !== 4'b0000) $display("FAIL reset_mid_flags got=%b exp=0000", {data_valid, frame_err, overrun, busy}); else n_pass++;
    seen = 1'b0;
    data_ready = 1'b1;
    for (int i = 0; i < WIDTH + 4; i++) begin
      drive_bit(1'b0);
      if (data_valid || frame_err || busy) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL reset_aborted_frame got=%b exp=0", seen); else n_pass++;

    // a buffered word is lost on reset
    data_ready = 1'b0;
    send_body(8'h6B); drive_bit(1'b0);
    n_total++; if (data_out !== 8'h6B) $display("FAIL reset_pre_buf got=%h exp=6b", data_out); else n_pass++;
    rst = 1'b1; drive_bit(1'b0); rst = 1'b0;
    n_total++; if ({data_valid, data_out} !== {1'b0, 8'h00}) $display("FAIL reset_buf_lost got=%b/%h exp=0/00", data_valid, data_out); else n_pass++;
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] exp;
    data_ready = 1'b1;
    sb_q.push_back(8'hA5);
    send_body(8'hA5);
    n_total++; if ({data_valid, frame_err} !== 2'b00) $display("FAIL single_early got=%b exp=00", {data_valid, frame_err}); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy); else n_pass++;
    drive_bit(1'b0);
    exp = sb_q.pop_front();
    n_total++; if (data_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", data_valid); else n_pass++;
    n_total++; if (data_out !== exp) $display("FAIL single_data got=%h exp=%h", data_out, exp); else n_pass++;
    n_total++; if ({frame_err, overrun, busy} !== 3'b000) $display("FAIL single_flags got=%b exp=000", {frame_err, overrun, busy}); else n_pass++;
    drive_bit(1'b0);
    n_total++; if (data_valid !== 1'b0) $display("FAIL single_one_cycle got=%b exp=0", data_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp;
    data_ready = 1'b1;
    sb_q.push_back(8'h3C);
    sb_q.push_back(8'hFF);
    send_body(8'h3C); drive_bit(1'b0);
    exp = sb_q.pop_front();
    n_total++; if ({data_valid, data_out} !== {1'b1, exp}) $display("FAIL b2b_first got=%b/%h exp=1/%h", data_valid, data_out, exp); else n_pass++;
    send_body(8'hFF);
    n_total++; if ({data_valid, frame_err, busy} !== 3'b001) $display("FAIL b2b_mid got=%b exp=001", {data_valid, frame_err, busy}); else n_pass++;
    drive_bit(1'b0);
    exp = sb_q.pop_front();
    n_total++; if ({data_valid, data_out} !== {1'b1, exp}) $display("FAIL b2b_second got=%b/%h exp=1/%h", data_valid, data_out, exp); else n_pass++;
    n_total++; if (frame_err !== 1'b0) $display("FAIL b2b_err got=%b exp=0", frame_err); else n_pass++;
    drive_bit(1'b0);
  endtask

  task automatic test_bad_stop();
    logic [WIDTH-1:0] exp;
    data_ready = 1'b1;
    send_body(8'h5A); drive_bit(1'b1);
    n_total++; if ({frame_err, data_valid} !== 2'b10) $display("FAIL badstop_pulse got=%b exp=10", {frame_err, data_valid}); else n_pass++;
    drive_bit(1'b0);
    n_total++; if ({frame_err, data_valid, busy} !== 3'b000) $display("FAIL badstop_after got=%b exp=000", {frame_err, data_valid, busy}); else n_pass++;
    sb_q.push_back(8'h01);
    send_body(8'h01); drive_bit(1'b0);
    exp = sb_q.pop_front();
    n_total++; if ({data_valid, data_out, frame_err} !== {1'b1, exp, 1'b0}) $display("FAIL badstop_next got=%b/%h/%b exp=1/%h/0", data_valid, data_out, frame_err, exp); else n_pass++;
    drive_bit(1'b0);
  endtask

  task automatic test_overrun();
    logic [WIDTH-1:0] exp;
    data_ready = 1'b0;
    sb_q.push_back(8'h11);
    send_body(8'h11); drive_bit(1'b0);
    exp = sb_q.pop_front();
    n_total++; if ({data_valid, data_out, overrun} !== {1'b1, exp, 1'b0}) $display("FAIL ovr_first got=%b/%h/%b exp=1/%h/0", data_valid, data_out, overrun, exp); else n_pass++;
    send_body(8'h22); drive_bit(1'b0);
    n_total++; if (overrun !== 1'b1) $display("FAIL ovr_set got=%b exp=1", overrun); else n_pass++;
    n_total++; if ({data_valid, data_out} !== {1'b1, exp}) $display("FAIL ovr_hold got=%b/%h exp=1/%h", data_valid, data_out, exp); else n_pass++;
    drive_bit(1'b0);
    n_total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky got=%b exp=1", overrun); else n_pass++;
    data_ready = 1'b1;
    drive_bit(1'b0);
    data_ready = 1'b0;
    n_total++; if ({data_valid, overrun} !== 2'b00) $display("FAIL ovr_clear got=%b exp=00", {data_valid, overrun}); else n_pass++;

    // consume and commit in the same cycle
    sb_q.push_back(8'h11);
    send_body(8'h11); drive_bit(1'b0);
    exp = sb_q.pop_front();
    n_total++; if (data_out !== exp) $display("FAIL ovr_sim_first got=%h exp=%h", data_out, exp); else n_pass++;
    sb_q.push_back(8'h22);
    send_body(8'h22);
    data_ready = 1'b1;
    drive_bit(1'b0);
    exp = sb_q.pop_front();
    n_total++; if ({data_valid, data_out, overrun} !== {1'b1, exp, 1'b0}) $display("FAIL ovr_sim_load got=%b/%h/%b exp=1/%h/0", data_valid, data_out, overrun, exp); else n_pass++;
    drive_bit(1'b0);
    n_total++; if (data_valid !== 1'b0) $display("FAIL ovr_sim_drain got=%b exp=0", data_valid); else n_pass++;
  endtask

`ifdef SIPO_PARITY_CHK_EN
  task automatic test_parity();
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] w;
    data_ready = 1'b1;
    sb_q.push_back(8'h07);
    send_body(8'h07); drive_bit(1'b0);
    exp = sb_q.pop_front();
    n_total++; if ({data_valid, data_out, frame_err} !== {1'b1, exp, 1'b0}) $display("FAIL par_good got=%b/%h/%b exp=1/%h/0", data_valid, data_out, frame_err, exp); else n_pass++;
    drive_bit(1'b0);
    w = 8'h07;
    drive_bit(1'b1);
    for (int i = 0; i < WIDTH; i++) drive_bit(w[i]);
    drive_bit(1'b0);
    drive_bit(1'b0);
    n_total++; if ({frame_err, data_valid} !== 2'b10) $display("FAIL par_bad got=%b exp=10", {frame_err, data_valid}); else n_pass++;
    drive_bit(1'b0);
    n_total++; if ({frame_err, data_valid} !== 2'b00) $display("FAIL par_after got=%b exp=00", {frame_err, data_valid}); else n_pass++;
  endtask
`endif

  initial begin
    n_pass = 0;
    n_total = 0;
    D = 1'b0;
    rst = 1'b1;
    data_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_stop();
    test_overrun();
`ifdef SIPO_PARITY_CHK_EN
    test_parity();
`endif
    n_total++; if (sb_q.size() != 0) $display("FAIL scoreboard_left got=%0d exp=0", sb_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
